// File: rtl/line_clear_engine_if.sv
// Handshake/bus bundle between the piece-lock logic (master) and line_clear_engine (slave).
interface line_clear_engine_if #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int LW      = $clog2(BOARD_H + 1)
);
    logic                         start;
    logic [BOARD_W*BOARD_H-1:0]   board_in;
    logic                         busy;
    logic                         done;
    logic [BOARD_W*BOARD_H-1:0]   board_out;
    logic [LW-1:0]                lines_cleared;
    logic [15:0]                  score_delta;
    logic [15:0]                  total_lines;
    logic [BOARD_H-1:0]           flash_row;

    modport master (
        output start, board_in,
        input  busy, done, board_out, lines_cleared, score_delta, total_lines, flash_row
    );

    modport slave (
        input  start, board_in,
        output busy, done, board_out, lines_cleared, score_delta, total_lines, flash_row
    );
endinterface

// File: rtl/line_clear_engine.sv
// Tetris multi-row line-clear engine: scans bottom-to-top, collapses full rows, reports lines/score.
// Optional feature macro: LINE_FLASH_EN (adds a FLASH hold of FLASH_CYCLES per full row).
module line_clear_engine #(
    parameter int BOARD_W      = 10,
    parameter int BOARD_H      = 20,
    parameter int FLASH_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    line_clear_engine_if.slave   bus
);
    localparam int LW = $clog2(BOARD_H + 1);
    localparam int PW = $clog2(BOARD_H);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLASH, S_COLLAPSE, S_DONE} state_t;

    state_t                      r_state;
    logic [BOARD_W-1:0]          r_board [BOARD_H];
    logic [PW-1:0]               r_ptr;
    logic [LW-1:0]               r_count;
    logic                        r_busy;
    logic                        r_done;
    logic [BOARD_W*BOARD_H-1:0]  r_board_out;
    logic [LW-1:0]               r_lines;
    logic [15:0]                 r_score;
    logic [15:0]                 r_total;
    logic [BOARD_H-1:0]          r_flash_row;
`ifdef LINE_FLASH_EN
    localparam int FCW = $clog2(FLASH_CYCLES + 1);
    logic [FCW-1:0]              r_flash_cnt;
`endif

    logic                        w_row_full;
    logic [16:0]                 w_total_sum;
    logic [BOARD_W*BOARD_H-1:0]  w_board_flat;

    assign w_row_full  = &r_board[r_ptr];
    assign w_total_sum = {1'b0, r_total} + 17'(r_count);

    always_comb begin
        w_board_flat = '0;
        for (int unsigned r = 0; r < BOARD_H; r++) begin
            w_board_flat[r*BOARD_W +: BOARD_W] = r_board[r];
        end
    end

    function automatic logic [15:0] score_for(input logic [LW-1:0] n);
        if (n >= LW'(4))      return 16'd800;
        else if (n == LW'(3)) return 16'd500;
        else if (n == LW'(2)) return 16'd300;
        else if (n == LW'(1)) return 16'd100;
        else                  return 16'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_board_out <= '0;
            r_lines     <= '0;
            r_score     <= '0;
            r_total     <= '0;
            r_flash_row <= '0;
`ifdef LINE_FLASH_EN
            r_flash_cnt <= '0;
`endif
            for (int unsigned r = 0; r < BOARD_H; r++) begin
                r_board[r] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int unsigned r = 0; r < BOARD_H; r++) begin
                            r_board[r] <= bus.board_in[r*BOARD_W +: BOARD_W];
                        end
                        r_ptr   <= PW'(BOARD_H - 1);
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_row_full) begin
`ifdef LINE_FLASH_EN
                        r_flash_row <= BOARD_H'(1) << r_ptr;
                        r_flash_cnt <= '0;
                        r_state     <= S_FLASH;
`else
                        r_state     <= S_COLLAPSE;
`endif
                    end else if (r_ptr == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_ptr <= r_ptr - PW'(1);
                    end
                end
`ifdef LINE_FLASH_EN
                S_FLASH: begin
                    if (r_flash_cnt == FCW'(FLASH_CYCLES - 1)) begin
                        r_flash_row <= '0;
                        r_state     <= S_COLLAPSE;
                    end else begin
                        r_flash_cnt <= r_flash_cnt + FCW'(1);
                    end
                end
`endif
                // Shift rows 0..ptr-1 down by one; ptr stays so the new row at ptr is re-scanned.
                S_COLLAPSE: begin
                    for (int unsigned r = 0; r < BOARD_H; r++) begin
                        if (r == 0) begin
                            r_board[r] <= '0;
                        end else if (PW'(r) <= r_ptr) begin
                            r_board[r] <= r_board[r-1];
                        end
                    end
                    r_count <= r_count + LW'(1);
                    r_state <= S_SCAN;
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_board_out <= w_board_flat;
                    r_lines     <= r_count;
                    r_score     <= score_for(r_count);
                    r_total     <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.board_out     = r_board_out;
    assign bus.lines_cleared = r_lines;
    assign bus.score_delta   = r_score;
    assign bus.total_lines   = r_total;
    assign bus.flash_row     = r_flash_row;
endmodule
